// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its load/read scheduler.
// The opcode and operand types are the instruction register's own; the rest belongs to the scheduler.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic [4:0]         address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instr_t;

   localparam int unsigned DEPTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FULL
   } sched_state_e;

endpackage

// File: rtl/instr_reg_scheduler_if.sv
// Requester, write and read signals between the scheduler and the instruction register side.
// Signal names match the instruction register's tb_ifc, so the two connect with no glue logic.
interface instr_reg_scheduler_if;
   import instr_register_pkg::*;

   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   opcode_t    req0_opcode, req1_opcode;
   operand_t   req0_operand_a, req0_operand_b;
   operand_t   req1_operand_a, req1_operand_b;

   logic       load_en;
   address_t   write_pointer;
   opcode_t    opcode;
   operand_t   operand_a, operand_b;

   logic       rd_req;
   address_t   rd_ptr;
   address_t   read_pointer;
   logic       rd_valid;

   logic [5:0] count;
   logic       full;

   modport slave (
      input  req0_valid, req1_valid, req0_opcode, req1_opcode,
             req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b,
             rd_req, rd_ptr,
      output req0_ready, req1_ready, load_en, write_pointer, opcode,
             operand_a, operand_b, read_pointer, rd_valid, count, full
   );

   modport master (
      output req0_valid, req1_valid, req0_opcode, req1_opcode,
             req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b,
             rd_req, rd_ptr,
      input  req0_ready, req1_ready, load_en, write_pointer, opcode,
             operand_a, operand_b, read_pointer, rd_valid, count, full
   );

endinterface

// File: rtl/instr_reg_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: a tie goes to the requester that was not granted last.
// rr_last resets to 1, so requester 0 wins the first tie.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);

   logic rr_last_q;

   always_comb begin
      // NOTE: default first so every path assigns grant_o and no latch is inferred.
      grant_o = 2'b00;
      if (enable_i) begin
         unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = rr_last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= 1'b1;
      end else if (|grant_o) begin
         rr_last_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Arbitrates two requesters into registered instruction-register writes and schedules reads.
// With WRAP_EN=0 the block locks in FULL after 32 loads until reset.
module instr_reg_scheduler
   import instr_register_pkg::*;
#(
   parameter bit WRAP_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   instr_reg_scheduler_if.slave bus
);

   localparam logic [5:0] DEPTH_CNT = 6'(DEPTH);

   sched_state_e state_q;
   logic         load_en_q;
   address_t     write_pointer_q;
   logic [5:0]   count_q;
   instr_t       instr_q;

   address_t     read_pointer_q;
   logic         rd_valid_q;
   logic         hazard_q;

   logic [1:0]   grant;
   logic         slot_free;
   logic         xfer;
   logic         hazard;
   instr_t       req_instr;

   // In LOAD with 31 entries written, the pending load is the 32nd, so nothing more may enter.
   assign slot_free = reset_n && (state_q != FULL) &&
                      (WRAP_EN || (state_q == IDLE) || (count_q != DEPTH_CNT - 6'd1));

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (reset_n),
      .valid_i  ({bus.req1_valid, bus.req0_valid}),
      .enable_i (slot_free),
      .grant_o  (grant)
   );

   assign xfer      = |grant;
   assign req_instr = grant[1] ? {bus.req1_opcode, bus.req1_operand_a, bus.req1_operand_b}
                               : {bus.req0_opcode, bus.req0_operand_a, bus.req0_operand_b};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         load_en_q       <= 1'b0;
         write_pointer_q <= '0;
         count_q         <= '0;
         instr_q         <= '{opc: ZERO, op_a: '0, op_b: '0};
      end else begin
         load_en_q <= xfer;
         if (xfer) begin
            instr_q <= req_instr;
         end
         if (load_en_q) begin
            write_pointer_q <= write_pointer_q + 5'd1;
            if (count_q != DEPTH_CNT) begin
               count_q <= count_q + 6'd1;
            end
         end
         unique case (state_q)
            IDLE: if (xfer) state_q <= LOAD;
            LOAD: begin
               if (!WRAP_EN && (count_q == DEPTH_CNT - 6'd1)) begin
                  state_q <= FULL;
               end else if (!xfer) begin
                  state_q <= IDLE;
               end
            end
            FULL:    state_q <= FULL;
            default: state_q <= IDLE;
         endcase
      end
   end

   // A read of the entry being written this cycle waits one extra cycle for the new data.
   assign hazard = bus.rd_req && load_en_q && (bus.rd_ptr == write_pointer_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_pointer_q <= '0;
         rd_valid_q     <= 1'b0;
         hazard_q       <= 1'b0;
      end else begin
         if (bus.rd_req) begin
            read_pointer_q <= bus.rd_ptr;
         end
         hazard_q   <= hazard;
         rd_valid_q <= (bus.rd_req && !hazard) || hazard_q;
      end
   end

   assign bus.req0_ready    = grant[0];
   assign bus.req1_ready    = grant[1];
   assign bus.load_en       = load_en_q;
   assign bus.write_pointer = write_pointer_q;
   assign bus.opcode        = instr_q.opc;
   assign bus.operand_a     = instr_q.op_a;
   assign bus.operand_b     = instr_q.op_b;
   assign bus.read_pointer  = read_pointer_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.count         = count_q;
   assign bus.full          = (state_q == FULL);

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler: a wrapping instance with an instruction-register model,
// and a non-wrapping instance for the full-lock behaviour.
module tb_instr_reg_scheduler;
   import instr_register_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   instr_reg_scheduler_if w_if ();
   instr_reg_scheduler_if f_if ();

   instr_reg_scheduler #(.WRAP_EN(1'b1)) dut_w (.clk(clk), .reset_n(reset_n), .bus(w_if.slave));
   instr_reg_scheduler #(.WRAP_EN(1'b0)) dut_f (.clk(clk), .reset_n(reset_n), .bus(f_if.slave));

   // Instruction register model: writes on load_en, result computed from the stored entry.
   opcode_t  mem_op [DEPTH];
   operand_t mem_a  [DEPTH];
   operand_t mem_b  [DEPTH];

   always @(posedge clk) begin
      if (w_if.load_en) begin
         mem_op[w_if.write_pointer] <= w_if.opcode;
         mem_a[w_if.write_pointer]  <= w_if.operand_a;
         mem_b[w_if.write_pointer]  <= w_if.operand_b;
      end
   end

   function automatic logic signed [63:0] compute(opcode_t o, operand_t a, operand_t b);
      case (o)
         PASSA:   return a;
         PASSB:   return b;
         ADD:     return a + b;
         SUB:     return a - b;
         MULT:    return a * b;
         DIV:     return (b == 0) ? 64'sd0 : a / b;
         MOD:     return (b == 0) ? 64'sd0 : a % b;
         default: return 64'sd0;
      endcase
   endfunction

   function automatic logic signed [63:0] rd_result();
      return compute(mem_op[w_if.read_pointer], mem_a[w_if.read_pointer], mem_b[w_if.read_pointer]);
   endfunction

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_if.req0_valid = 1'b0; w_if.req1_valid = 1'b0; w_if.rd_req = 1'b0; w_if.rd_ptr = '0;
      w_if.req0_opcode = ZERO; w_if.req0_operand_a = '0; w_if.req0_operand_b = '0;
      w_if.req1_opcode = ZERO; w_if.req1_operand_a = '0; w_if.req1_operand_b = '0;
      f_if.req0_valid = 1'b0; f_if.req1_valid = 1'b0; f_if.rd_req = 1'b0; f_if.rd_ptr = '0;
      f_if.req0_opcode = ZERO; f_if.req0_operand_a = '0; f_if.req0_operand_b = '0;
      f_if.req1_opcode = ZERO; f_if.req1_operand_a = '0; f_if.req1_operand_b = '0;
   endtask

   task automatic push_w(input opcode_t o, input operand_t a, input operand_t b);
      w_if.req0_valid = 1'b1; w_if.req0_opcode = o; w_if.req0_operand_a = a; w_if.req0_operand_b = b;
      cyc();
   endtask

   task automatic read_w(input address_t p, input logic signed [63:0] exp);
      w_if.rd_req = 1'b1; w_if.rd_ptr = p;
      cyc();
      w_if.rd_req = 1'b0;
      check("rd_valid", w_if.rd_valid, 1);
      check("read_pointer", w_if.read_pointer, p);
      check("read_result", rd_result(), exp);
      cyc();
      check("rd_valid_drop", w_if.rd_valid, 0);
   endtask

   typedef struct {
      logic       v0, v1;
      opcode_t    op0;
      operand_t   a0, b0;
      opcode_t    op1;
      operand_t   a1, b1;
      logic       er0, er1, eload;
      opcode_t    eop;
      operand_t   ea, eb;
      logic [4:0] ewp;
      logic [5:0] ecnt;
   } vec_t;

   typedef struct {
      address_t             ptr;
      logic signed [63:0]   res;
   } rd_vec_t;

   vec_t    vecs [10];
   rd_vec_t rds  [7];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // v0 v1 | op0 a0 b0 | op1 a1 b1 | r0 r1 load | op a b | wp cnt
      vecs[0] = '{1'b1, 1'b1, ADD,   32'sd5,   32'sd3, SUB,   32'sd10,  -32'sd1 + 32'sd5,
                  1'b1, 1'b0, 1'b1, ADD,   32'sd5,   32'sd3, 5'd0, 6'd0};
      vecs[1] = '{1'b1, 1'b1, MULT,  32'sd6,   32'sd7, PASSA, 32'sd9,   32'sd1,
                  1'b0, 1'b1, 1'b1, PASSA, 32'sd9,   32'sd1, 5'd1, 6'd1};
      vecs[2] = '{1'b1, 1'b1, PASSB, 32'sd2,   32'sd8, DIV,   32'sd20,  32'sd5,
                  1'b1, 1'b0, 1'b1, PASSB, 32'sd2,   32'sd8, 5'd2, 6'd2};
      vecs[3] = '{1'b1, 1'b1, MOD,   32'sd17,  32'sd5, ADD,   32'sd100, -32'sd1,
                  1'b0, 1'b1, 1'b1, ADD,   32'sd100, -32'sd1, 5'd3, 6'd3};
      vecs[4] = '{1'b0, 1'b1, ZERO,  32'sd0,   32'sd0, SUB,   32'sd50,  32'sd8,
                  1'b0, 1'b1, 1'b1, SUB,   32'sd50,  32'sd8, 5'd4, 6'd4};
      vecs[5] = '{1'b0, 1'b0, ADD,   32'sd1,   32'sd1, ADD,   32'sd1,   32'sd1,
                  1'b0, 1'b0, 1'b0, SUB,   32'sd50,  32'sd8, 5'd5, 6'd5};
      vecs[6] = '{1'b1, 1'b0, MULT,  32'sd3,   32'sd4, ZERO,  32'sd0,   32'sd0,
                  1'b1, 1'b0, 1'b1, MULT,  32'sd3,   32'sd4, 5'd5, 6'd5};
      vecs[7] = '{1'b1, 1'b0, ADD,   32'sd1,   32'sd2, ZERO,  32'sd0,   32'sd0,
                  1'b1, 1'b0, 1'b1, ADD,   32'sd1,   32'sd2, 5'd6, 6'd6};
      vecs[8] = '{1'b1, 1'b1, PASSA, 32'sd7,   32'sd0, MOD,   32'sd9,   32'sd4,
                  1'b0, 1'b1, 1'b1, MOD,   32'sd9,   32'sd4, 5'd7, 6'd7};
      vecs[9] = '{1'b0, 1'b0, ZERO,  32'sd0,   32'sd0, ZERO,  32'sd0,   32'sd0,
                  1'b0, 1'b0, 1'b0, MOD,   32'sd9,   32'sd4, 5'd8, 6'd8};

      rds[0] = '{5'd0, 64'sd8};
      rds[1] = '{5'd1, 64'sd9};
      rds[2] = '{5'd3, 64'sd99};
      rds[3] = '{5'd4, 64'sd42};
      rds[4] = '{5'd5, 64'sd12};
      rds[5] = '{5'd6, 64'sd3};
      rds[6] = '{5'd7, 64'sd1};

      // Reset state, and ready held low while reset is asserted.
      reset_n = 1'b0;
      idle_inputs();
      #2;
      check("rst_load_en", w_if.load_en, 0);
      check("rst_write_pointer", w_if.write_pointer, 0);
      check("rst_read_pointer", w_if.read_pointer, 0);
      check("rst_rd_valid", w_if.rd_valid, 0);
      check("rst_count", w_if.count, 0);
      check("rst_full", f_if.full, 0);
      check("rst_opcode", w_if.opcode, ZERO);
      check("rst_operand_a", w_if.operand_a, 0);
      w_if.req0_valid = 1'b1; w_if.req1_valid = 1'b1;
      #1;
      check("rst_ready0", w_if.req0_ready, 0);
      check("rst_ready1", w_if.req1_ready, 0);
      cyc();
      reset_n = 1'b1;

      // Table: first vector transfers on the first edge after reset release.
      for (int i = 0; i < 10; i++) begin
         w_if.req0_valid = vecs[i].v0; w_if.req0_opcode = vecs[i].op0;
         w_if.req0_operand_a = vecs[i].a0; w_if.req0_operand_b = vecs[i].b0;
         w_if.req1_valid = vecs[i].v1; w_if.req1_opcode = vecs[i].op1;
         w_if.req1_operand_a = vecs[i].a1; w_if.req1_operand_b = vecs[i].b1;
         #1;
         check($sformatf("v%0d_ready0", i), w_if.req0_ready, vecs[i].er0);
         check($sformatf("v%0d_ready1", i), w_if.req1_ready, vecs[i].er1);
         cyc();
         check($sformatf("v%0d_load_en", i), w_if.load_en, vecs[i].eload);
         check($sformatf("v%0d_opcode", i), w_if.opcode, vecs[i].eop);
         check($sformatf("v%0d_operand_a", i), w_if.operand_a, vecs[i].ea);
         check($sformatf("v%0d_operand_b", i), w_if.operand_b, vecs[i].eb);
         check($sformatf("v%0d_write_pointer", i), w_if.write_pointer, vecs[i].ewp);
         check($sformatf("v%0d_count", i), w_if.count, vecs[i].ecnt);
      end
      idle_inputs();
      cyc();

      for (int i = 0; i < 7; i++) read_w(rds[i].ptr, rds[i].res);

      // Reset while a load is pending, then the first tie goes to req0.
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) push_w(PASSA, 32'(i), 32'sd0);
      check("pend_load_en", w_if.load_en, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_load_en", w_if.load_en, 0);
      check("mid_rst_write_pointer", w_if.write_pointer, 0);
      check("mid_rst_count", w_if.count, 0);
      check("mid_rst_ready0", w_if.req0_ready, 0);
      cyc();
      w_if.req0_opcode = ADD; w_if.req0_operand_a = 32'sd20; w_if.req0_operand_b = 32'sd22;
      w_if.req1_valid = 1'b1; w_if.req1_opcode = SUB;
      w_if.req1_operand_a = 32'sd1; w_if.req1_operand_b = 32'sd1;
      reset_n = 1'b1;
      #1;
      check("tie_ready0", w_if.req0_ready, 1);
      check("tie_ready1", w_if.req1_ready, 0);
      cyc();
      check("tie_load_en", w_if.load_en, 1);
      check("tie_opcode", w_if.opcode, ADD);
      check("tie_write_pointer", w_if.write_pointer, 0);
      check("tie_count", w_if.count, 0);
      w_if.req1_valid = 1'b0;

      // Back-to-back stream, then a read of the entry being written.
      for (int i = 1; i < 4; i++) begin
         push_w(PASSA, 32'(i), 32'sd0);
         check($sformatf("b2b%0d_load_en", i), w_if.load_en, 1);
         check($sformatf("b2b%0d_write_pointer", i), w_if.write_pointer, i);
      end
      push_w(ADD, 32'sd30, 32'sd3);
      w_if.req0_valid = 1'b0;
      check("haz_write_pointer", w_if.write_pointer, 4);
      w_if.rd_req = 1'b1; w_if.rd_ptr = 5'd4;
      cyc();
      w_if.rd_req = 1'b0;
      check("haz_rd_valid_n1", w_if.rd_valid, 0);
      cyc();
      check("haz_rd_valid_n2", w_if.rd_valid, 1);
      check("haz_read_pointer", w_if.read_pointer, 4);
      check("haz_result", rd_result(), 33);
      cyc();

      // Wrap: 33rd load lands in entry 0, count saturates at 32.
      for (int i = 5; i < 32; i++) push_w(PASSA, 32'(i), 32'sd0);
      push_w(SUB, 32'sd50, 32'sd7);
      w_if.req0_valid = 1'b0;
      check("wrap_load_en", w_if.load_en, 1);
      check("wrap_write_pointer", w_if.write_pointer, 0);
      check("wrap_count_during", w_if.count, 32);
      cyc();
      check("wrap_count", w_if.count, 32);
      check("wrap_full", w_if.full, 0);
      check("wrap_write_pointer_next", w_if.write_pointer, 1);
      w_if.req0_valid = 1'b1;
      #1;
      check("wrap_ready0", w_if.req0_ready, 1);
      w_if.req0_valid = 1'b0;
      read_w(5'd0, 43);

      // Non-wrapping instance: 32 loads lock it in FULL.
      for (int k = 0; k < 32; k++) begin
         f_if.req0_valid = 1'b1; f_if.req0_opcode = PASSB;
         f_if.req0_operand_a = 32'sd0; f_if.req0_operand_b = 32'(k);
         #1;
         check($sformatf("fill%0d_ready0", k), f_if.req0_ready, 1);
         cyc();
      end
      f_if.req1_valid = 1'b1;
      #1;
      check("last_load_en", f_if.load_en, 1);
      check("last_write_pointer", f_if.write_pointer, 31);
      check("last_ready0", f_if.req0_ready, 0);
      check("last_ready1", f_if.req1_ready, 0);
      cyc();
      check("full_flag", f_if.full, 1);
      check("full_load_en", f_if.load_en, 0);
      check("full_count", f_if.count, 32);
      check("full_ready0", f_if.req0_ready, 0);
      check("full_ready1", f_if.req1_ready, 0);
      cyc();
      check("full_hold_load_en", f_if.load_en, 0);
      check("full_hold_count", f_if.count, 32);
      check("full_hold_flag", f_if.full, 1);
      f_if.rd_req = 1'b1; f_if.rd_ptr = 5'd7;
      cyc();
      f_if.rd_req = 1'b0;
      check("full_rd_valid", f_if.rd_valid, 1);
      check("full_read_pointer", f_if.read_pointer, 7);
      cyc();
      check("full_rd_valid_drop", f_if.rd_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instr_reg_scheduler.md
INSTR_REG_SCHEDULER -- requirements
Module: instr_reg_scheduler

Interface
REQ-001 Parameter: WRAP_EN, 1, 1 = write pointer wraps 31->0 and keeps accepting; 0 = stop at 32 entries.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an instruction to load.
REQ-005 req0_ready / req1_ready  output  1 each  requester's instruction accepted this cycle.
REQ-006 req0_opcode / req1_opcode  input  opcode_t  requested opcode.
REQ-007 req0_operand_a/b, req1_operand_a/b  input  operand_t  requested operands.
REQ-008 load_en  output  1  write strobe to instruction register.
REQ-009 write_pointer  output  5  destination entry.
REQ-010 opcode  output  opcode_t  registered opcode to instruction register.
REQ-011 operand_a / operand_b  output  operand_t  registered operands.
REQ-012 rd_req  input  1  read request.
REQ-013 rd_ptr  input  5  entry to read.
REQ-014 read_pointer  output  5  read address to instruction register.
REQ-015 rd_valid  output  1  instruction_word valid for the captured read_pointer.
REQ-016 count  output  6  entries loaded since reset, saturating at 32.
REQ-017 full  output  1  high when WRAP_EN=0 and count==32.

Function
REQ-018 Transfer on reqN_valid & reqN_ready; ready is combinational from valid, rr_last and state; at most one ready high per cycle.
REQ-019 Round robin: only one valid -> grant it; both valid -> grant the requester not in rr_last; rr_last updates on every transfer.
REQ-020 Transfer in cycle N -> load_en=1 in cycle N+1 with opcode/operands of the granted requester and current write_pointer.
REQ-021 write_pointer increments by 1 on the edge ending each load_en cycle; 31+1 wraps to 0.
REQ-022 Back-to-back transfers every cycle are accepted; load_en stays high continuously, no bubbles.
REQ-023 FSM states: IDLE (no load pending), LOAD (load_en high), FULL (WRAP_EN=0, count==32).
REQ-024 Transitions: IDLE->LOAD on transfer; LOAD->LOAD on transfer; LOAD->IDLE on no transfer; LOAD->FULL when the load brings count to 32 and WRAP_EN=0.
REQ-025 FULL: both ready low, load_en low; exit only by reset.
REQ-026 count increments on each load_en cycle, saturates at 32 (WRAP_EN=1 holds 32 after wrap).
REQ-027 Read: rd_req in cycle N -> read_pointer=rd_ptr from edge N+1; rd_valid=1 in cycle N+1 only.
REQ-028 Read/write same entry: rd_req in the same cycle as load_en with rd_ptr==write_pointer delays rd_valid one further cycle (N+2) so new data is returned.
REQ-029 Reads are independent of FSM state, including FULL.
REQ-030 opcode/operand outputs hold their last value when load_en=0.

Reset
REQ-031 reset_n low asynchronously forces: state=IDLE, load_en=0, write_pointer=0, read_pointer=0, rd_valid=0, count=0, full=0, opcode=ZERO, operands=0, rr_last=1 (req0 wins first tie).
REQ-032 Reset mid-load discards the pending load; ready outputs low while reset_n low.
REQ-033 First transfer is possible in the first posedge after reset_n rises.

Structure
REQ-034 opcode_t and operand_t come from instr_register_pkg; the FSM state enum and the depth constant (32) are added to that package.
REQ-035 One sub-module, rr_arbiter2 (two-requester round-robin grant with rr_last register).
REQ-036 The block connects to the instruction register through tb_ifc signal names with no glue logic.

Verification
REQ-037 Single requester: req0 ADD a=5 b=3 one cycle -> next cycle load_en=1, write_pointer=0, opcode=ADD; read entry 0 -> result 8.
REQ-038 Contention: both valid for 4 cycles -> grants req0,req1,req0,req1; write_pointer 0..3.
REQ-039 Wrap: WRAP_EN=1, 33 loads -> 33rd written at entry 0, count=32, full=0.
REQ-040 Full: WRAP_EN=0, 32 loads -> full=1, both ready low, further valid ignored, count=32.
REQ-041 Hazard: rd_req rd_ptr=4 during load to entry 4 -> rd_valid two cycles later with new data.
REQ-042 Reset after 3 loads while a load is pending -> load_en=0, write_pointer=0, count=0, then req0 wins the first tie.
